// File: rtl/rv32_pipeline_ctrl_if.sv
// Pipeline control bus between the pipeline stages and rv32_pipeline_ctrl.
// The master side drives stage requests and consumes stop/redirect/bubble
// controls. The slave side is the controller.
interface rv32_pipeline_ctrl_if;
  // Requests from the pipeline stages and the debug unit
  logic        decode_stall;
  logic        exec_branch_taken;
  logic [31:0] exec_branch_target;
  logic        mem_busy;
  logic        trap_req;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        resume_req;

  // Controls back to the pipeline stages
  logic        fetch_stop;
  logic        decode_stop;
  logic        exec_stop;
  logic        fetch_set_pc;
  logic [31:0] fetch_pc;
  logic        decode_set_nop;
  logic [31:0] decode_set_nop_pc;
  logic        exec_set_nop;
  logic        halted;
  logic        drain_timeout;
  logic [1:0]  state;

  modport master (
    output decode_stall, exec_branch_taken, exec_branch_target, mem_busy,
           trap_req, trap_vector, halt_req, resume_req,
    input  fetch_stop, decode_stop, exec_stop, fetch_set_pc, fetch_pc,
           decode_set_nop, decode_set_nop_pc, exec_set_nop, halted,
           drain_timeout, state
  );

  modport slave (
    input  decode_stall, exec_branch_taken, exec_branch_target, mem_busy,
           trap_req, trap_vector, halt_req, resume_req,
    output fetch_stop, decode_stop, exec_stop, fetch_set_pc, fetch_pc,
           decode_set_nop, decode_set_nop_pc, exec_set_nop, halted,
           drain_timeout, state
  );
endinterface

// File: rtl/rv32_pipeline_ctrl.sv
// RV32 pipeline hazard/redirect controller.
// States: BOOT (one cycle, redirect to RESET_PC), RUN, TRAP (drain memory,
// then redirect to the latched vector), HALT (debug halt).
// Stage controls are Mealy functions of the registered state and the current
// requests; while resetn is low they are forced to their reset values.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cycles and
// flush_count performance counters.
module rv32_pipeline_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  rv32_pipeline_ctrl_if.slave   ctrl
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StTrap = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam logic [7:0] DrainMax = 8'(DRAIN_TIMEOUT);

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic        drain_to_q, drain_to_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] trap_vec_q, trap_vec_d;

  // Next-state and Mealy stage-control decode
  always_comb begin
    ctrl.fetch_stop        = 1'b0;
    ctrl.decode_stop       = 1'b0;
    ctrl.exec_stop         = 1'b0;
    ctrl.fetch_set_pc      = 1'b0;
    ctrl.fetch_pc          = RESET_PC;
    ctrl.decode_set_nop    = 1'b0;
    ctrl.decode_set_nop_pc = RESET_PC;
    ctrl.exec_set_nop      = 1'b0;

    state_d     = state_q;
    halted_d    = halted_q;
    drain_to_d  = drain_to_q;
    drain_cnt_d = drain_cnt_q;
    trap_vec_d  = trap_vec_q;

    unique case (state_q)
      StBoot: begin
        ctrl.fetch_set_pc   = 1'b1;
        ctrl.decode_set_nop = 1'b1;
        state_d             = StRun;
      end

      StRun: begin
        if (ctrl.mem_busy) begin
          // Memory stall freezes everything; no redirect is accepted
          ctrl.fetch_stop  = 1'b1;
          ctrl.decode_stop = 1'b1;
          ctrl.exec_stop   = 1'b1;
        end else if (ctrl.trap_req) begin
          // Squash decode/exec, hold fetch until memory has drained
          trap_vec_d          = ctrl.trap_vector;
          ctrl.fetch_stop     = 1'b1;
          ctrl.decode_set_nop = 1'b1;
          ctrl.exec_set_nop   = 1'b1;
          state_d             = StTrap;
        end else if (ctrl.exec_branch_taken) begin
          ctrl.fetch_set_pc      = 1'b1;
          ctrl.fetch_pc          = ctrl.exec_branch_target;
          ctrl.decode_set_nop    = 1'b1;
          ctrl.decode_set_nop_pc = ctrl.exec_branch_target;
        end else if (ctrl.halt_req) begin
          ctrl.fetch_stop     = 1'b1;
          ctrl.decode_set_nop = 1'b1;
          halted_d            = 1'b1;
          state_d             = StHalt;
        end else if (ctrl.decode_stall) begin
          // Decode inserts its own bubble, so only fetch is held
          ctrl.fetch_stop = 1'b1;
        end
      end

      StTrap: begin
        ctrl.fetch_stop     = 1'b1;
        ctrl.decode_set_nop = 1'b1;
        if (ctrl.mem_busy) begin
          if (drain_cnt_q < DrainMax) begin
            drain_cnt_d = drain_cnt_q + 8'd1;
          end
          if (drain_cnt_d == DrainMax) begin
            drain_to_d = 1'b1;
          end
        end else begin
          ctrl.fetch_set_pc      = 1'b1;
          ctrl.fetch_pc          = trap_vec_q;
          ctrl.decode_set_nop_pc = trap_vec_q;
          drain_cnt_d            = 8'd0;
          state_d                = StRun;
        end
      end

      StHalt: begin
        ctrl.fetch_stop     = 1'b1;
        ctrl.decode_set_nop = 1'b1;
        if (ctrl.resume_req) begin
          halted_d = 1'b0;
          state_d  = StRun;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase

    // Reset holds every stage frozen without redirect or bubble
    if (!resetn) begin
      ctrl.fetch_stop        = 1'b1;
      ctrl.decode_stop       = 1'b1;
      ctrl.exec_stop         = 1'b1;
      ctrl.fetch_set_pc      = 1'b0;
      ctrl.fetch_pc          = RESET_PC;
      ctrl.decode_set_nop    = 1'b0;
      ctrl.decode_set_nop_pc = RESET_PC;
      ctrl.exec_set_nop      = 1'b0;
    end
  end

  // Controller state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StBoot;
      halted_q    <= 1'b0;
      drain_to_q  <= 1'b0;
      drain_cnt_q <= 8'd0;
      trap_vec_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      drain_to_q  <= drain_to_d;
      drain_cnt_q <= drain_cnt_d;
      trap_vec_q  <= trap_vec_d;
    end
  end

  assign ctrl.state         = state_q;
  assign ctrl.halted        = halted_q;
  assign ctrl.drain_timeout = drain_to_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        run_stall;
  logic        flush_accept;

  // Performance counter increments; both wrap naturally at 2^32
  always_comb begin
    run_stall    = (state_q == StRun) &&
                   (ctrl.fetch_stop || ctrl.decode_stop || ctrl.exec_stop);
    flush_accept = (state_q == StRun) && !ctrl.mem_busy &&
                   (ctrl.trap_req || ctrl.exec_branch_taken);
    stall_cycles_d = stall_cycles_q + (run_stall ? 32'd1 : 32'd0);
    flush_count_d  = flush_count_q + (flush_accept ? 32'd1 : 32'd0);
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Self-checking bench for rv32_pipeline_ctrl (RESET_PC=32'h100, DRAIN_TIMEOUT=15).
// Inputs change on the falling edge; Mealy outputs are sampled 2 ns later,
// well before the next rising edge.
module tb_rv32_pipeline_ctrl;
  localparam logic [31:0] R = 32'h0000_0100;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rv32_pipeline_ctrl_if bus ();
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  rv32_pipeline_ctrl #(
    .RESET_PC      (R),
    .DRAIN_TIMEOUT (15)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .ctrl   (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  typedef struct packed {
    logic        dstall;
    logic        br;
    logic [31:0] tgt;
    logic        busy;
    logic        trap;
    logic [31:0] vec;
    logic        halt;
    logic        resume;
  } in_t;

  typedef struct packed {
    logic [1:0]  st;
    logic        fstop;
    logic        dstop;
    logic        estop;
    logic        fset;
    logic [31:0] fpc;
    logic        dnop;
    logic [31:0] dpc;
    logic        enop;
    logic        halted;
    logic        dto;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int    checks   = 0;
  int    failures = 0;
  out_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];

  function automatic in_t ii(logic ds, logic br, logic [31:0] tgt, logic busy,
                             logic trap, logic [31:0] vec, logic halt, logic res);
    in_t r;
    r.dstall = ds;   r.br = br;     r.tgt = tgt;   r.busy = busy;
    r.trap   = trap; r.vec = vec;   r.halt = halt; r.resume = res;
    return r;
  endfunction

  // pc applies to both fetch_pc and decode_set_nop_pc
  function automatic out_t oo(logic [1:0] st, logic fs, logic ds, logic es, logic fset,
                              logic dnop, logic enop, logic [31:0] pc, logic hl, logic dto);
    out_t r;
    r.st = st; r.fstop = fs; r.dstop = ds; r.estop = es; r.fset = fset;
    r.fpc = pc; r.dnop = dnop; r.dpc = pc; r.enop = enop; r.halted = hl; r.dto = dto;
    return r;
  endfunction

  function automatic out_t actual();
    out_t r;
    r.st = bus.state; r.fstop = bus.fetch_stop; r.dstop = bus.decode_stop;
    r.estop = bus.exec_stop; r.fset = bus.fetch_set_pc; r.fpc = bus.fetch_pc;
    r.dnop = bus.decode_set_nop; r.dpc = bus.decode_set_nop_pc;
    r.enop = bus.exec_set_nop; r.halted = bus.halted; r.dto = bus.drain_timeout;
    return r;
  endfunction

  task automatic drive(in_t i);
    bus.decode_stall       = i.dstall;
    bus.exec_branch_taken  = i.br;
    bus.exec_branch_target = i.tgt;
    bus.mem_busy           = i.busy;
    bus.trap_req           = i.trap;
    bus.trap_vector        = i.vec;
    bus.halt_req           = i.halt;
    bus.resume_req         = i.resume;
  endtask

  task automatic expect_out(string n, out_t o);
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  task automatic check_now();
    out_t  e;
    out_t  a;
    string n;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: actual=empty required=entry");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = actual();
      if (a !== e) begin
        failures++;
        $display("FAIL %s: actual=%h required=%h", n, a, e);
      end
    end
  endtask

  // One cycle: drive, record expectation, sample, advance to next falling edge
  task automatic apply(string n, in_t i, out_t o);
    drive(i);
    expect_out(n, o);
    #2;
    check_now();
    @(negedge clk);
  endtask

  task automatic check_val(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", n, a, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  i0;
    in_t  busy_in;
    out_t rst_o;
    i0      = ii(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    busy_in = ii(0, 0, 32'h0, 1, 0, 32'h0, 0, 0);
    rst_o   = oo(2'd0, 1, 1, 1, 0, 0, 0, R, 0, 0);

    // Vector table: each row is one cycle evaluated in the pre-edge state
    tbl.push_back('{"boot", i0, oo(2'd0, 0, 0, 0, 1, 1, 0, R, 0, 0)});
    tbl.push_back('{"run_idle", i0, oo(2'd1, 0, 0, 0, 0, 0, 0, R, 0, 0)});
    tbl.push_back('{"run_stall", ii(1, 0, 32'h0, 0, 0, 32'h0, 0, 0),
                    oo(2'd1, 1, 0, 0, 0, 0, 0, R, 0, 0)});
    tbl.push_back('{"run_busy_blocks_all", ii(1, 1, 32'h44, 1, 1, 32'h80, 1, 0),
                    oo(2'd1, 1, 1, 1, 0, 0, 0, R, 0, 0)});
    tbl.push_back('{"branch_over_stall", ii(1, 1, 32'h40, 0, 0, 32'h0, 0, 0),
                    oo(2'd1, 0, 0, 0, 1, 1, 0, 32'h40, 0, 0)});
    tbl.push_back('{"branch_over_halt", ii(0, 1, 32'h60, 0, 0, 32'h0, 1, 0),
                    oo(2'd1, 0, 0, 0, 1, 1, 0, 32'h60, 0, 0)});
    tbl.push_back('{"halt_req", ii(0, 0, 32'h0, 0, 0, 32'h0, 1, 0),
                    oo(2'd1, 1, 0, 0, 0, 1, 0, R, 0, 0)});
    tbl.push_back('{"halt_ignores_trap_branch", ii(1, 1, 32'h50, 0, 1, 32'h90, 0, 0),
                    oo(2'd3, 1, 0, 0, 0, 1, 0, R, 1, 0)});
    tbl.push_back('{"halt_hold", i0, oo(2'd3, 1, 0, 0, 0, 1, 0, R, 1, 0)});
    tbl.push_back('{"halt_resume_with_halt", ii(0, 0, 32'h0, 0, 0, 32'h0, 1, 1),
                    oo(2'd3, 1, 0, 0, 0, 1, 0, R, 1, 0)});
    tbl.push_back('{"resumed", i0, oo(2'd1, 0, 0, 0, 0, 0, 0, R, 0, 0)});
    tbl.push_back('{"trap_with_branch", ii(0, 1, 32'h44, 0, 1, 32'h80, 0, 0),
                    oo(2'd1, 1, 0, 0, 0, 1, 1, R, 0, 0)});
    for (int k = 1; k <= 20; k++) begin
      tbl.push_back('{$sformatf("trap_drain_%0d", k), busy_in,
                      oo(2'd2, 1, 0, 0, 0, 1, 0, R, 0, (k >= 16))});
    end
    tbl.push_back('{"trap_exit_redirect", i0, oo(2'd2, 1, 0, 0, 1, 1, 0, 32'h80, 0, 1)});
    tbl.push_back('{"after_trap_sticky", i0, oo(2'd1, 0, 0, 0, 0, 0, 0, R, 0, 1)});

    // Reset state, with resetn low from time 0
    drive(i0);
    #2;
    expect_out("reset_values", rst_o);
    check_now();
    @(negedge clk);
    resetn = 1'b1;

    for (int n = 0; n < tbl.size(); n++) begin
      apply(tbl[n].name, tbl[n].i, tbl[n].o);
    end

    // Reset asserted mid-TRAP takes effect without waiting for a clock edge
    apply("trap2_enter", ii(0, 0, 32'h0, 0, 1, 32'hC0, 0, 0),
          oo(2'd1, 1, 0, 0, 0, 1, 1, R, 0, 1));
    apply("trap2_busy", busy_in, oo(2'd2, 1, 0, 0, 0, 1, 0, R, 0, 1));
    drive(busy_in);
    #3;
    resetn = 1'b0;
    #1;
    expect_out("reset_mid_trap_async", rst_o);
    check_now();
    @(negedge clk);
    #2;
    expect_out("reset_mid_trap_hold", rst_o);
    check_now();
    @(negedge clk);
    resetn = 1'b1;
    apply("boot_after_reset", i0, oo(2'd0, 0, 0, 0, 1, 1, 0, R, 0, 0));
    apply("run_after_reset", i0, oo(2'd1, 0, 0, 0, 0, 0, 0, R, 0, 0));

    // Drain counter and sticky flag must restart from zero after reset
    apply("trap3_enter", ii(0, 0, 32'h0, 0, 1, 32'hA0, 0, 0),
          oo(2'd1, 1, 0, 0, 0, 1, 1, R, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      apply($sformatf("trap3_drain_%0d", k), busy_in, oo(2'd2, 1, 0, 0, 0, 1, 0, R, 0, 0));
    end
    apply("trap3_exit", i0, oo(2'd2, 1, 0, 0, 1, 1, 0, 32'hA0, 0, 0));
    apply("trap3_run", i0, oo(2'd1, 0, 0, 0, 0, 0, 0, R, 0, 0));

    // Reset asserted mid-HALT
    apply("halt2_req", ii(0, 0, 32'h0, 0, 0, 32'h0, 1, 0), oo(2'd1, 1, 0, 0, 0, 1, 0, R, 0, 0));
    apply("halt2_hold", i0, oo(2'd3, 1, 0, 0, 0, 1, 0, R, 1, 0));
    #3;
    resetn = 1'b0;
    #1;
    expect_out("reset_mid_halt_async", rst_o);
    check_now();
    @(negedge clk);

`ifdef PIPE_PERF_CNT_EN
    @(negedge clk);
    #2;
    check_val("perf_stall_reset", stall_cycles, 32'd0);
    check_val("perf_flush_reset", flush_count, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    apply("perf_boot", i0, oo(2'd0, 0, 0, 0, 1, 1, 0, R, 0, 0));
    for (int k = 0; k < 3; k++) begin
      apply("perf_stall", ii(1, 0, 32'h0, 0, 0, 32'h0, 0, 0),
            oo(2'd1, 1, 0, 0, 0, 0, 0, R, 0, 0));
    end
    apply("perf_br1", ii(0, 1, 32'h200, 0, 0, 32'h0, 0, 0),
          oo(2'd1, 0, 0, 0, 1, 1, 0, 32'h200, 0, 0));
    apply("perf_br2", ii(0, 1, 32'h300, 0, 0, 32'h0, 0, 0),
          oo(2'd1, 0, 0, 0, 1, 1, 0, 32'h300, 0, 0));
    drive(i0);
    #2;
    check_val("perf_stall_cycles", stall_cycles, 32'd3);
    check_val("perf_flush_count", flush_count, 32'd2);
`endif

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
